// File: rtl/pwm_gate_gen_if.sv
// Handshake bundle between the off-time controller/run control and the PWM gate generator.
interface pwm_gate_gen_if #(
    parameter int unsigned CNT_WIDTH = 18
) ();
    logic                 enable;
    logic [CNT_WIDTH-1:0] off_div;
    logic                 pwm_rdy;
    logic                 pwm_en;
    logic                 gate_hi;
    logic                 gate_lo;
    logic                 period_done;
    logic                 stale;

    modport master (
        output enable, off_div, pwm_rdy,
        input  pwm_en, gate_hi, gate_lo, period_done, stale
    );

    modport slave (
        input  enable, off_div, pwm_rdy,
        output pwm_en, gate_hi, gate_lo, period_done, stale
    );
endinterface

// File: rtl/pwm_gate_gen.sv
// Fixed-on-time / variable-off-time PWM gate generator with registered gate outputs.
// Define PWM_DEADTIME_EN to build the complementary low-side output with dead time.
module pwm_gate_gen #(
    parameter int unsigned ON_TIME    = 40,
    parameter int unsigned CNT_WIDTH  = 18,
    parameter int unsigned TOTAL_TIME = 400,
    parameter int unsigned DEAD_TIME  = 4
) (
    input logic           clk,
    input logic           n_rst,
    pwm_gate_gen_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

    localparam logic [CNT_WIDTH-1:0] OnLast = CNT_WIDTH'(ON_TIME - 1);
    localparam logic [CNT_WIDTH-1:0] OnEn   = CNT_WIDTH'(ON_TIME - 2);
    localparam logic [CNT_WIDTH-1:0] OffMax = CNT_WIDTH'(TOTAL_TIME - 1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] off_lat_q, off_lat_d;
    logic                 period_start;
    logic                 gate_lo_d;
    logic                 gate_hi_q, gate_lo_q, pwm_en_q, period_done_q, stale_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        period_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d        = '0;
                period_start = bus.enable;
            end
            StOn: begin
                if (cnt_q == OnLast) begin
                    cnt_d = '0;
                    // Zero off time: chain straight into the next ON so gate_hi never dips.
                    if (off_lat_q != '0) state_d = StOff;
                    else                 period_start = 1'b1;
                end
            end
            StOff: begin
                if (cnt_q == off_lat_q - 1'b1) period_start = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // Safety abort overrides everything, including a period boundary.
        if (!bus.enable) begin
            state_d      = StIdle;
            cnt_d        = '0;
            period_start = 1'b0;
        end else if (period_start) begin
            state_d = StOn;
            cnt_d   = '0;
        end

        off_lat_d = off_lat_q;
        if (period_start && bus.pwm_rdy) begin
            off_lat_d = (bus.off_div > OffMax) ? OffMax : bus.off_div;
        end
    end

`ifdef PWM_DEADTIME_EN
    localparam logic [CNT_WIDTH:0] Dead = (CNT_WIDTH+1)'(DEAD_TIME);

    // Empty window whenever off_lat <= 2*DEAD_TIME, so no separate length check is needed.
    assign gate_lo_d = (state_d == StOff) && ({1'b0, cnt_d} >= Dead) &&
                       ({1'b0, cnt_d} + Dead < {1'b0, off_lat_q});
`else
    logic unused_dead_time;
    assign unused_dead_time = (DEAD_TIME != 0);
    assign gate_lo_d        = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            off_lat_q     <= '0;
            gate_hi_q     <= 1'b0;
            gate_lo_q     <= 1'b0;
            pwm_en_q      <= 1'b0;
            period_done_q <= 1'b0;
            stale_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            off_lat_q     <= off_lat_d;
            gate_hi_q     <= (state_d == StOn);
            gate_lo_q     <= gate_lo_d;
            pwm_en_q      <= (state_d == StOn) && (cnt_d == OnEn);
            period_done_q <= (state_d == StOff) && (cnt_d == off_lat_q - 1'b1);
            stale_q       <= period_start && !bus.pwm_rdy;
        end
    end

    assign bus.gate_hi     = gate_hi_q;
    assign bus.gate_lo     = gate_lo_q;
    assign bus.pwm_en      = pwm_en_q;
    assign bus.period_done = period_done_q;
    assign bus.stale       = stale_q;

endmodule

// File: doc/pwm_gate_gen.md
# pwm_gate_gen

Fixed-on-time, variable-off-time PWM gate generator that sits directly downstream of the off-time controller. Each switching period it drives the high-side gate for `ON_TIME` clocks, then holds it off for a latched `off_div` clocks. It pulses `pwm_en` to request the next off-time calculation and samples the result only when the controller reports `pwm_rdy`. An optional complementary low-side output with dead time is compiled in by macro.

## Interface
- `ON_TIME`, 40: high-side on duration, clocks (≥ 2)
- `CNT_WIDTH`, 18: width of `off_div` and internal counters
- `TOTAL_TIME`, 400: off-time clamp; the applied off time is ≤ `TOTAL_TIME`-1
- `DEAD_TIME`, 4: low-side guard band at each edge of OFF, clocks (used only with the macro)

- `clk`  in  1  system clock
- `n_rst`  in  1  asynchronous active-low reset
- `enable`  in  1  run request; low forces gates off
- `off_div`  in  `CNT_WIDTH`  off time from the controller, clocks
- `pwm_rdy`  in  1  controller idle; `off_div` valid
- `pwm_en`  out  1  one-clock request for a new off-time calculation
- `gate_hi`  out  1  high-side gate drive
- `gate_lo`  out  1  low-side gate drive (0 when the macro is absent)
- `period_done`  out  1  one-clock pulse on the last OFF clock
- `stale`  out  1  one-clock pulse when a period starts with `pwm_rdy`=0

## Operation
- States: IDLE, ON, OFF. A counter `cnt` counts clocks within the state; `off_lat` holds the latched off time.
- Reset: state=IDLE, `cnt`=0, `off_lat`=0, and every output is 0.
- Period start, entered from IDLE with `enable`=1, or from the end of OFF:
  - If `pwm_rdy`=1, latch `off_lat` = min(`off_div`, `TOTAL_TIME`-1).
  - Otherwise keep `off_lat` unchanged and pulse `stale`.
- ON:
  - `gate_hi`=1 for exactly `ON_TIME` clocks.
  - `pwm_en`=1 on the clock where `cnt`=`ON_TIME`-2, so the controller has the whole OFF phase to compute.
  - After the last ON clock, go to OFF if `off_lat`>0. If `off_lat`=0, start a new period and stay in ON, so `gate_hi` is continuous.
- OFF:
  - `gate_hi`=0 for `off_lat` clocks.
  - On the last OFF clock, pulse `period_done`.
  - Next state is ON if `enable`=1, else IDLE.
- `enable`=0 in ON or OFF: on the next clock, go to IDLE with both gates 0. There is no period completion; this is the safety abort.
- `gate_hi` and `gate_lo` come directly from flops and are never both 1.

## Timing
- `gate_hi` rises 1 clock after `enable` is sampled high in IDLE.
- Period length = `ON_TIME` + `off_lat` clocks.
- `pwm_en` is never asserted outside ON, and at most once per period.
- `off_div` is sampled only on the clock before the ON phase begins. Changes at any other time have no effect on the current period.
- `pwm_rdy` dropping mid-period is ignored until the next period start.
- Reset asserted mid-period: all outputs go to 0 immediately (asynchronous). After release, the block waits in IDLE for `enable`.

## Configuration
- `PWM_DEADTIME_EN` defined:
  - `gate_lo`=1 during OFF except the first `DEAD_TIME` and last `DEAD_TIME` OFF clocks.
  - If `off_lat` ≤ 2·`DEAD_TIME`, `gate_lo` stays 0 for that period.
  - `gate_lo`=0 in IDLE and ON.
- `PWM_DEADTIME_EN` undefined: `gate_lo` is tied to 0, and the dead-time counter logic is absent.

## Test plan
- `off_div`=100, `pwm_rdy`=1, `enable` rises → `gate_hi` high 40 clocks, low 100 clocks, repeating. `pwm_en` pulses once per period, at the 39th ON clock. `period_done` pulses on the 100th OFF clock.
- `off_div`=1000 → `off_lat`=399; period = 439 clocks.
- `off_div`=0 → `gate_hi` stays high continuously; `pwm_en` pulses every 40 clocks.
- `pwm_rdy`=0 at a period start with previous `off_lat`=50 → `stale` pulses; OFF lasts 50 clocks.
- `enable` dropped at ON clock 10 → `gate_hi`=0 on the next clock; state IDLE; no `period_done` pulse.
- With `PWM_DEADTIME_EN`:
  - `off_div`=20 → `gate_lo` high on OFF clocks 5–16.
  - `off_div`=8 → `gate_lo` stays 0.
  - In all cases `gate_hi`&`gate_lo` is never 1.
